// File: rtl/sram_pkg.sv
// Shared types and constants for the 1RW masked SRAM with post-reset init sweep.
package sram_pkg;

  typedef enum logic {
    SRAM_INIT  = 1'b0,
    SRAM_READY = 1'b1
  } sram_state_e;

  localparam int SRAM_RD_LAT_BASE = 1;

endpackage

// File: rtl/sram_1rw_masked_init_if.sv
// RW0 request/response bundle for sram_1rw_masked_init, with FSM state exposed for observation.
// Handshake: a request is taken on a clock edge iff RW0_en && RW0_ready; RW0_rvalid pulses one cycle per read result.
interface sram_1rw_masked_init_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int UNITS  = 10,
  parameter int DATA_W = 70
) ();

  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [UNITS-1:0]  RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic              RW0_ready;
  logic              RW0_rvalid;
  logic [DATA_W-1:0] RW0_rdata;
  sram_state_e       dbg_state;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_ready, RW0_rvalid, RW0_rdata, dbg_state
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_ready, RW0_rvalid, RW0_rdata, dbg_state
  );

endinterface

// File: rtl/sram_init_seq.sv
// Post-reset init sequencer: walks every address once with a write strobe, then parks in READY.
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              o_init_we,
  output logic [ADDR_W-1:0] o_init_addr,
  output logic              o_ready,
  output sram_state_e       o_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  sram_state_e       r_state;
  sram_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_init_ptr;
  logic [ADDR_W-1:0] w_init_ptr_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= SRAM_INIT;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    o_init_we      = 1'b0;
    o_ready        = 1'b0;
    case (r_state)
      SRAM_INIT: begin
        o_init_we = 1'b1;
        if (r_init_ptr == LAST_ADDR) w_state_nxt = SRAM_READY;
        else                         w_init_ptr_nxt = r_init_ptr + 1'b1;
      end
      SRAM_READY: o_ready = 1'b1;
      default:    w_state_nxt = SRAM_INIT;
    endcase
  end

  assign o_init_addr = r_init_ptr;
  assign o_state     = r_state;

endmodule

// File: rtl/sram_1rw_masked_init.sv
// Single-port SRAM with per-granule write mask, registered read with hold, and hardware init sweep.
// Define SRAM_OUT_REG_EN to add a second output register stage (read latency 2).
module sram_1rw_masked_init
  import sram_pkg::*;
#(
  parameter int                         DEPTH    = 256,
  parameter int                         UNITS    = 10,
  parameter int                         UNIT_W   = 7,
  parameter logic [UNITS*UNIT_W-1:0]    INIT_VAL = '0
) (
  input logic                    clock,
  input logic                    reset,
  sram_1rw_masked_init_if.slave  rw0
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int DATA_W = UNITS * UNIT_W;

  logic [DATA_W-1:0] r_ram [DEPTH];

  logic              w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic              w_ready;
  sram_state_e       w_state;

  sram_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clock       (clock),
    .reset       (reset),
    .o_init_we   (w_init_we),
    .o_init_addr (w_init_addr),
    .o_ready     (w_ready),
    .o_state     (w_state)
  );

  logic w_addr_ok;
  logic w_acc;
  logic w_wr;
  logic w_rd;

  // Out-of-range addresses only exist for non-power-of-2 depths.
  assign w_addr_ok = ({1'b0, rw0.RW0_addr} < (ADDR_W + 1)'(DEPTH));
  assign w_acc     = w_ready & rw0.RW0_en;
  assign w_wr      = w_acc & rw0.RW0_wmode;
  assign w_rd      = w_acc & ~rw0.RW0_wmode;

  // The init sweep owns the write port until ready.
  always_ff @(posedge clock) begin
    if (!w_ready) begin
      if (w_init_we) r_ram[w_init_addr] <= INIT_VAL;
    end else if (w_wr && w_addr_ok) begin
      for (int i = 0; i < UNITS; i++) begin
        if (rw0.RW0_wmask[i])
          r_ram[rw0.RW0_addr][i*UNIT_W +: UNIT_W] <= rw0.RW0_wdata[i*UNIT_W +: UNIT_W];
      end
    end
  end

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_addr_ok ? r_ram[rw0.RW0_addr] : INIT_VAL;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic              r_rvalid_q;
  logic [DATA_W-1:0] r_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid_q <= 1'b0;
      r_rdata_q  <= '0;
    end else begin
      r_rvalid_q <= r_rvalid;
      if (r_rvalid) r_rdata_q <= r_rdata;
    end
  end

  assign rw0.RW0_rvalid = r_rvalid_q;
  assign rw0.RW0_rdata  = r_rdata_q;
`else
  assign rw0.RW0_rvalid = r_rvalid;
  assign rw0.RW0_rdata  = r_rdata;
`endif

  assign rw0.RW0_ready = w_ready;
  assign rw0.dbg_state = w_state;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Bench for sram_1rw_masked_init: behavioural array model with latency queue, directed and random stimulus.
module tb_sram_1rw_masked_init;
  import sram_pkg::*;

  localparam int DEPTH  = 256;
  localparam int UNITS  = 10;
  localparam int UNIT_W = 7;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 70;
  localparam logic [DATA_W-1:0] INIT = '0;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = SRAM_RD_LAT_BASE + 1;
`else
  localparam int LAT = SRAM_RD_LAT_BASE;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_1rw_masked_init_if #(.ADDR_W(ADDR_W), .UNITS(UNITS), .DATA_W(DATA_W)) rw0 ();

  sram_1rw_masked_init #(
    .DEPTH    (DEPTH),
    .UNITS    (UNITS),
    .UNIT_W   (UNIT_W),
    .INIT_VAL (INIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .rw0   (rw0)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_ram [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                due_q [$];
  int                m_cyc = 0;
  int                tick = 0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                chk_en = 1'b0;

  always @(posedge clock) begin
    bit rdy;
    tick++;
    if (reset) begin
      for (int a = 0; a < DEPTH; a++) m_ram[a] = INIT;
      exp_q.delete();
      due_q.delete();
      m_cyc    = 0;
      m_rvalid = 1'b0;
      m_rdata  = '0;
      chk_en   = 1'b1;
    end else begin
      rdy = (m_cyc >= DEPTH);
      if (m_cyc < DEPTH) m_cyc++;
      if (rdy && rw0.RW0_en) begin
        if (rw0.RW0_wmode) begin
          for (int u = 0; u < UNITS; u++)
            if (rw0.RW0_wmask[u])
              m_ram[rw0.RW0_addr][u*UNIT_W +: UNIT_W] = rw0.RW0_wdata[u*UNIT_W +: UNIT_W];
        end else begin
          exp_q.push_back(m_ram[rw0.RW0_addr]);
          due_q.push_back(tick + LAT - 1);
        end
      end
      m_rvalid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == tick) begin
        void'(due_q.pop_front());
        m_rdata  = exp_q.pop_front();
        m_rvalid = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("ready",  DATA_W'(rw0.RW0_ready),  DATA_W'(m_cyc >= DEPTH));
      check("state",  DATA_W'(rw0.dbg_state),  DATA_W'((m_cyc >= DEPTH) ? SRAM_READY : SRAM_INIT));
      check("rvalid", DATA_W'(rw0.RW0_rvalid), DATA_W'(m_rvalid));
      check("rdata",  rw0.RW0_rdata,           m_rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic wm, input logic [ADDR_W-1:0] a,
                       input logic [UNITS-1:0] mask, input logic [DATA_W-1:0] d);
    @(posedge clock);
    #2;
    rw0.RW0_en    = en;
    rw0.RW0_wmode = wm;
    rw0.RW0_addr  = a;
    rw0.RW0_wmask = mask;
    rw0.RW0_wdata = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [UNITS-1:0] mask, input logic [DATA_W-1:0] d);
    drive(1'b1, 1'b1, a, mask, d);
  endtask

  task automatic rd_check(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    drive(1'b1, 1'b0, a, '0, '0);
    idle();
    repeat (LAT - 1) @(posedge clock);
    @(negedge clock);
    check({name, "_rvalid"}, DATA_W'(rw0.RW0_rvalid), DATA_W'(1));
    check({name, "_rdata"}, rw0.RW0_rdata, exp);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    rw0.RW0_en = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
  endtask

  // Counts low-ready cycles right after a reset edge; bounded.
  task automatic count_init(input string name);
    int n = 0;
    forever begin
      @(negedge clock);
      if (n == 0) begin
        check({name, "_rvalid0"}, DATA_W'(rw0.RW0_rvalid), DATA_W'(0));
        check({name, "_rdata0"},  rw0.RW0_rdata, DATA_W'(0));
      end
      if (rw0.RW0_ready || n > 1000) break;
      n++;
    end
    check({name, "_len"}, DATA_W'(n), DATA_W'(DEPTH));
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] bb [3];

  initial begin
    rw0.RW0_en    = 1'b0;
    rw0.RW0_wmode = 1'b0;
    rw0.RW0_addr  = '0;
    rw0.RW0_wmask = '0;
    rw0.RW0_wdata = '0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    count_init("sweep1");

    rd_check("init_a0",   8'd0,   INIT);
    rd_check("init_a128", 8'd128, INIT);
    rd_check("init_a255", 8'd255, INIT);

    wr(8'd3, 10'h3FF, 70'h3F_FFFF_FFFF_FFFF_FFFF);
    wr(8'd3, 10'b0000000001, 70'h0);
    rd_check("mask_a3", 8'd3, 70'h3F_FFFF_FFFF_FFFF_FF80);

    wr(8'd7, 10'h3FF, 70'h1234);
    rd_check("rd_a7", 8'd7, 70'h1234);
    wr(8'd7, 10'h3FF, 70'h55);
    idle();
    @(negedge clock);
    check("hold_rvalid", DATA_W'(rw0.RW0_rvalid), DATA_W'(0));
    check("hold_rdata",  rw0.RW0_rdata, 70'h1234);
    rd_check("rd_a7_new", 8'd7, 70'h55);

    bb[0] = 70'hA; bb[1] = 70'hB; bb[2] = 70'hC;
    wr(8'd1, 10'h3FF, bb[0]);
    wr(8'd2, 10'h3FF, bb[1]);
    wr(8'd3, 10'h3FF, bb[2]);
    fork
      begin
        drive(1'b1, 1'b0, 8'd1, '0, '0);
        drive(1'b1, 1'b0, 8'd2, '0, '0);
        drive(1'b1, 1'b0, 8'd3, '0, '0);
        idle();
      end
      begin
        @(posedge clock);
        #3;
        repeat (LAT) @(posedge clock);
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          check("b2b_rvalid", DATA_W'(rw0.RW0_rvalid), DATA_W'(1));
          check("b2b_rdata",  rw0.RW0_rdata, bb[k]);
        end
        @(negedge clock);
        check("b2b_end_rvalid", DATA_W'(rw0.RW0_rvalid), DATA_W'(0));
      end
    join

    // Reset with a read in flight.
    drive(1'b1, 1'b0, 8'd1, '0, '0);
    pulse_reset();
    count_init("sweep_rd");

    // Reset mid-sweep, with a dropped write during init.
    wr(8'd9, 10'h3FF, 70'h99);
    pulse_reset();
    repeat (10) idle();
    wr(8'd5, 10'h3FF, {DATA_W{1'b1}});
    repeat (89) idle();
    pulse_reset();
    count_init("sweep_mid");
    rd_check("drop_a5",  8'd5, INIT);
    rd_check("clr_a7",   8'd7, INIT);
    rd_check("clr_a3",   8'd3, INIT);

    // Randomised traffic; the compare process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)),
            10'($urandom_range(0, 1023)),
            DATA_W'({$urandom(), $urandom(), $urandom()}));
    end
    repeat (4) idle();
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
